// File: rtl/csr_access_unit_if.sv
// Bus bundle for the CSR access unit.
//  Request side  : req_valid/req_ready handshake plus decoded Zicsr fields.
//  CSR file side : read port (combinational data back) and write port.
//  Response side : resp_valid/resp_ready handshake with old value and error flag.
// The unit connects through modport slave; the execute stage / CSR file
// environment connects through modport master.
interface csr_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_csr_index;
  logic [31:0] req_rs1_data;
  logic [4:0]  req_rs1_uimm;
  logic [4:0]  req_rd_index;

  logic        read_enable_csr;
  logic [11:0] csr_read_index;
  logic [31:0] csr_read_data;
  logic        write_enable_csr;
  logic [11:0] csr_write_index;
  logic [31:0] csr_write_data;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rd_data;
  logic        resp_error;

  modport slave (
    input  req_valid, req_funct3, req_csr_index, req_rs1_data, req_rs1_uimm, req_rd_index,
    output req_ready,
    output read_enable_csr, csr_read_index,
    input  csr_read_data,
    output write_enable_csr, csr_write_index, csr_write_data,
    output resp_valid, resp_rd_data, resp_error,
    input  resp_ready
  );

  modport master (
    output req_valid, req_funct3, req_csr_index, req_rs1_data, req_rs1_uimm, req_rd_index,
    input  req_ready,
    input  read_enable_csr, csr_read_index,
    output csr_read_data,
    input  write_enable_csr, csr_write_index, csr_write_data,
    input  resp_valid, resp_rd_data, resp_error,
    output resp_ready
  );
endinterface

// File: rtl/csr_access_unit.sv
// csr_access_unit
//  Executes one Zicsr instruction per accepted request as a sequenced
//  read-modify-write against the approximation CSRs (ALU/MUL/DIV), returning
//  the old CSR value, or an error for an unimplemented index or funct3.
// Ports
//  clk   : clock, all state on posedge
//  reset : synchronous, active-high
//  bus   : csr_access_unit_if.slave (request, CSR file read/write, response)
module csr_access_unit #(
  parameter logic [11:0] ALU_CSR_ADDR = 12'h800,
  parameter logic [11:0] MUL_CSR_ADDR = 12'h801,
  parameter logic [11:0] DIV_CSR_ADDR = 12'h802
) (
  input  logic               clk,
  input  logic               reset,
  csr_access_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  op_kind_reg;      // funct3[1:0]: 01 write, 10 set, 11 clear
  logic [11:0] index_reg;
  logic [31:0] operand_reg;
  logic [31:0] old_reg;
  logic        need_write_reg;
  logic        error_reg;

  // Decode of the incoming request, only meaningful while accepting.
  logic        accept;
  logic        is_rw_in;
  logic        need_read_in;
  logic        need_write_in;
  logic        legal_in;
  logic [31:0] operand_in;

  always_comb begin
    accept        = bus.req_valid && (state_reg == IDLE);
    is_rw_in      = (bus.req_funct3[1:0] == 2'b01);
    // A CSRRW/CSRRWI with rd==0 discards the old value, so skip the read.
    need_read_in  = !(is_rw_in && (bus.req_rd_index == 5'd0));
    // Set/clear with a zero rs1 field are pure reads.
    need_write_in = is_rw_in || (bus.req_rs1_uimm != 5'd0);
    legal_in      = ((bus.req_csr_index == ALU_CSR_ADDR) ||
                     (bus.req_csr_index == MUL_CSR_ADDR) ||
                     (bus.req_csr_index == DIV_CSR_ADDR)) &&
                    (bus.req_funct3[1:0] != 2'b00);
    operand_in    = bus.req_funct3[2] ? {27'd0, bus.req_rs1_uimm} : bus.req_rs1_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      op_kind_reg    <= 2'b00;
      index_reg      <= 12'd0;
      operand_reg    <= 32'd0;
      old_reg        <= 32'd0;
      need_write_reg <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_kind_reg    <= bus.req_funct3[1:0];
        index_reg      <= bus.req_csr_index;
        operand_reg    <= operand_in;
        // Cleared here so skipped reads and errors report zero.
        old_reg        <= 32'd0;
        need_write_reg <= need_write_in;
        error_reg      <= !legal_in;
      end else if (state_reg == READ) begin
        old_reg <= bus.csr_read_data;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (!legal_in)         state_next = RESP;
          else if (need_read_in) state_next = READ;
          else                   state_next = WRITE;
        end
      end
      READ:    state_next = need_write_reg ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    if (bus.resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  logic [31:0] write_value;

  always_comb begin
    write_value = 32'd0;
    case (op_kind_reg)
      2'b01:   write_value = operand_reg;
      2'b10:   write_value = old_reg | operand_reg;
      2'b11:   write_value = old_reg & ~operand_reg;
      default: write_value = 32'd0;
    endcase
  end

  always_comb begin
    bus.req_ready        = (state_reg == IDLE);
    bus.read_enable_csr  = (state_reg == READ);
    bus.csr_read_index   = (state_reg == READ) ? index_reg : 12'd0;
    // Gated by reset so a reset landing in the WRITE cycle never commits.
    bus.write_enable_csr = (state_reg == WRITE) && !reset;
    bus.csr_write_index  = (state_reg == WRITE) ? index_reg : 12'd0;
    bus.csr_write_data   = (state_reg == WRITE) ? write_value : 32'd0;
    bus.resp_valid       = (state_reg == RESP);
    bus.resp_rd_data     = (state_reg == RESP) ? old_reg : 32'd0;
    bus.resp_error       = (state_reg == RESP) && error_reg;
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed testbench for csr_access_unit with a small three-register CSR
// file model (combinational read, negedge commit).
module tb_csr_access_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  csr_access_unit_if bus();

  csr_access_unit #(
    .ALU_CSR_ADDR(12'h800),
    .MUL_CSR_ADDR(12'h801),
    .DIV_CSR_ADDR(12'h802)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // CSR file model
  logic [31:0] alu_csr = 32'h0000_00F0;
  logic [31:0] mul_csr = 32'h0000_0012;
  logic [31:0] div_csr = 32'h0000_00FF;

  assign bus.csr_read_data = (bus.csr_read_index == 12'h800) ? alu_csr :
                             (bus.csr_read_index == 12'h801) ? mul_csr :
                             (bus.csr_read_index == 12'h802) ? div_csr : 32'd0;

  always @(negedge clk) begin
    if (bus.write_enable_csr) begin
      case (bus.csr_write_index)
        12'h800: alu_csr <= bus.csr_write_data;
        12'h801: mul_csr <= bus.csr_write_data;
        12'h802: div_csr <= bus.csr_write_data;
        default: ;
      endcase
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Captured during one transaction
  int          cycles;
  bit          saw_rd, saw_wr, both_high;
  logic [11:0] rd_idx, wr_idx;
  logic [31:0] wr_data;

  task automatic issue(input logic [2:0] f3, input logic [11:0] idx,
                       input logic [31:0] data, input logic [4:0] uimm,
                       input logic [4:0] rd);
    @(negedge clk);
    check("req_ready_before_accept", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid     = 1'b1;
    bus.req_funct3    = f3;
    bus.req_csr_index = idx;
    bus.req_rs1_data  = data;
    bus.req_rs1_uimm  = uimm;
    bus.req_rd_index  = rd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    cycles = 0; saw_rd = 0; saw_wr = 0; both_high = 0;
    rd_idx = 12'd0; wr_idx = 12'd0; wr_data = 32'd0;
    while (cycles < 10) begin
      @(negedge clk);
      cycles++;
      if (bus.read_enable_csr)  begin saw_rd = 1; rd_idx = bus.csr_read_index; end
      if (bus.write_enable_csr) begin saw_wr = 1; wr_idx = bus.csr_write_index; wr_data = bus.csr_write_data; end
      if (bus.read_enable_csr && bus.write_enable_csr) both_high = 1;
      if (bus.resp_valid) break;
    end
    check("resp_arrived", {31'd0, bus.resp_valid}, 32'd1);
    check("both_enables_never", {31'd0, both_high}, 32'd0);
    $display("txn f3=%b idx=0x%03h cycles=%0d rd=%0b wr=%0b wdata=0x%08h rdata=0x%08h err=%0b",
             f3, idx, cycles, saw_rd, saw_wr, wr_data, bus.resp_rd_data, bus.resp_error);
  endtask

  task automatic take_resp();
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
  endtask

  initial begin
    reset              = 1'b1;
    bus.req_valid      = 1'b0;
    bus.req_funct3     = 3'd0;
    bus.req_csr_index  = 12'd0;
    bus.req_rs1_data   = 32'd0;
    bus.req_rs1_uimm   = 5'd0;
    bus.req_rd_index   = 5'd0;
    bus.resp_ready     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready",  {31'd0, bus.req_ready}, 32'd1);
    check("reset_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("reset_read_en",    {31'd0, bus.read_enable_csr}, 32'd0);
    check("reset_write_en",   {31'd0, bus.write_enable_csr}, 32'd0);
    check("reset_rd_data",    bus.resp_rd_data, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // CSRRW 0x801, rs1 0xDEADBEEF, rd=5, MUL=0x12
    issue(3'b001, 12'h801, 32'hDEADBEEF, 5'd1, 5'd5);
    check("rw_cycles",    cycles, 32'd3);
    check("rw_read_idx",  {20'd0, rd_idx}, 32'h801);
    check("rw_write_idx", {20'd0, wr_idx}, 32'h801);
    check("rw_write_data", wr_data, 32'hDEADBEEF);
    check("rw_rd_data",   bus.resp_rd_data, 32'h12);
    check("rw_error",     {31'd0, bus.resp_error}, 32'd0);
    take_resp();
    check("rw_mul_after", mul_csr, 32'hDEADBEEF);

    // CSRRS 0x800 with rs1 field 0: read only
    issue(3'b010, 12'h800, 32'hFFFF_FFFF, 5'd0, 5'd7);
    check("rs0_cycles",   cycles, 32'd2);
    check("rs0_saw_read", {31'd0, saw_rd}, 32'd1);
    check("rs0_no_write", {31'd0, saw_wr}, 32'd0);
    check("rs0_rd_data",  bus.resp_rd_data, 32'hF0);
    take_resp();

    // CSRRCI 0x802 uimm 3, DIV=0xFF
    issue(3'b111, 12'h802, 32'hFFFF_FFFF, 5'd3, 5'd2);
    check("rci_cycles",     cycles, 32'd3);
    check("rci_write_data", wr_data, 32'hFC);
    check("rci_rd_data",    bus.resp_rd_data, 32'hFF);
    take_resp();
    check("rci_div_after",  div_csr, 32'hFC);

    // CSRRW to unimplemented 0x7C0
    issue(3'b001, 12'h7C0, 32'h1234_5678, 5'd1, 5'd4);
    check("err_cycles",   cycles, 32'd1);
    check("err_flag",     {31'd0, bus.resp_error}, 32'd1);
    check("err_rd_data",  bus.resp_rd_data, 32'd0);
    check("err_no_read",  {31'd0, saw_rd}, 32'd0);
    check("err_no_write", {31'd0, saw_wr}, 32'd0);
    take_resp();

    // Reserved funct3 000 on a legal index
    issue(3'b000, 12'h800, 32'h1, 5'd1, 5'd4);
    check("f3_err_cycles", cycles, 32'd1);
    check("f3_err_flag",   {31'd0, bus.resp_error}, 32'd1);
    check("f3_err_no_wr",  {31'd0, saw_wr}, 32'd0);
    take_resp();
    check("f3_err_alu",    alu_csr, 32'hF0);

    // CSRRWI 0x800 rd=0: write only, no read
    issue(3'b101, 12'h800, 32'hFFFF_FFFF, 5'd5, 5'd0);
    check("rwi_cycles",     cycles, 32'd2);
    check("rwi_no_read",    {31'd0, saw_rd}, 32'd0);
    check("rwi_write_data", wr_data, 32'd5);
    check("rwi_rd_data",    bus.resp_rd_data, 32'd0);
    take_resp();
    check("rwi_alu_after",  alu_csr, 32'd5);

    // CSRRSI 0x802 uimm 1 with response back-pressure; competing request ignored
    issue(3'b110, 12'h802, 32'd0, 5'd1, 5'd3);
    check("rsi_write_data", wr_data, 32'hFD);
    bus.req_valid     = 1'b1;
    bus.req_funct3    = 3'b001;
    bus.req_csr_index = 12'h800;
    bus.req_rs1_data  = 32'hAAAA_AAAA;
    bus.req_rd_index  = 5'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
      check("hold_rd_data",    bus.resp_rd_data, 32'hFC);
      check("hold_req_ready",  {31'd0, bus.req_ready}, 32'd0);
      check("hold_no_write",   {31'd0, bus.write_enable_csr}, 32'd0);
    end
    bus.req_valid = 1'b0;
    take_resp();
    @(negedge clk);
    check("hold_div_after", div_csr, 32'hFD);
    check("hold_alu_untouched", alu_csr, 32'd5);

    // Reset during the WRITE cycle of CSRRW 0x800
    bus.req_valid     = 1'b1;
    bus.req_funct3    = 3'b001;
    bus.req_csr_index = 12'h800;
    bus.req_rs1_data  = 32'h1234_5678;
    bus.req_rd_index  = 5'd1;
    @(posedge clk);              // accept -> READ
    #1 bus.req_valid = 1'b0;
    @(posedge clk);              // READ -> WRITE
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_write_gated", {31'd0, bus.write_enable_csr}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready",  {31'd0, bus.req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_alu_kept",   alu_csr, 32'd5);
    $display("txn reset-in-write alu=0x%08h req_ready=%0b", alu_csr, bus.req_ready);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
